fsqrt_sched: RTL and testbench

FSQRT_SCHED -- requirements
Module: fsqrt_sched

---
 rtl/fsqrt_sched.sv | 178 +++++++++++++++++
 tb/tb_fsqrt_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_sched.sv
// Two-port credit-based scheduler in front of one shared fixed-latency fsqrt pipeline.
// Optional per-port grant counters are enabled by defining FSQRT_SCHED_PERF_EN.
module fsqrt_sched #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_y,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_y,
  output logic [31:0] sq_x,
  input  logic [31:0] sq_y,
  output logic        busy
`ifdef FSQRT_SCHED_PERF_EN
  ,
  output logic [31:0] issue_cnt0,
  output logic [31:0] issue_cnt1
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic {PRIO_P0, PRIO_P1} prio_t;

  prio_t         r_prio;
  prio_t         w_prioNext;
  logic [CW-1:0] r_cred0, r_cred1;
  logic [LAT-1:0] r_pipeV, r_pipeP;
  logic [31:0]   r_fifo0 [DEPTH];
  logic [31:0]   r_fifo1 [DEPTH];
  logic [PW-1:0] r_wr0, r_rd0, r_wr1, r_rd1;
  logic [CW-1:0] r_cnt0, r_cnt1;

  logic w_elig0, w_elig1;
  logic w_grant0, w_grant1;
  logic w_push0, w_push1;
  logic w_pop0, w_pop1;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CW-1:0] countNext(input logic [CW-1:0] c,
                                              input logic inc, input logic dec);
    logic [CW-1:0] n;
    n = c;
    case ({inc, dec})
      2'b10:   n = c + 1'b1;
      2'b01:   n = c - 1'b1;
      default: n = c;
    endcase
    return n;
  endfunction

  // Grants are gated by rstn so every output reads 0 while reset is held.
  assign w_elig0  = rstn && req0_valid && (r_cred0 < CRED_MAX);
  assign w_elig1  = rstn && req1_valid && (r_cred1 < CRED_MAX);
  assign w_grant0 = w_elig0 && (!w_elig1 || (r_prio == PRIO_P0));
  assign w_grant1 = w_elig1 && (!w_elig0 || (r_prio == PRIO_P1));

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign sq_x       = w_grant0 ? req0_x : (w_grant1 ? req1_x : 32'h0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prio <= PRIO_P0;
    end else begin
      r_prio <= w_prioNext;
    end
  end

  always_comb begin
    w_prioNext = r_prio;
    if (w_grant0) begin
      w_prioNext = PRIO_P1;
    end else if (w_grant1) begin
      w_prioNext = PRIO_P0;
    end
  end

  // Stage k holds an issue k+1 cycles old; the last stage lines up with its sq_y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pipeV <= '0;
      r_pipeP <= '0;
    end else begin
      r_pipeV[0] <= w_grant0 || w_grant1;
      r_pipeP[0] <= w_grant1;
      for (int i = 1; i < LAT; i++) begin
        r_pipeV[i] <= r_pipeV[i-1];
        r_pipeP[i] <= r_pipeP[i-1];
      end
    end
  end

  assign w_push0 = r_pipeV[LAT-1] && !r_pipeP[LAT-1];
  assign w_push1 = r_pipeV[LAT-1] &&  r_pipeP[LAT-1];

  assign rsp0_valid = (r_cnt0 != '0);
  assign rsp1_valid = (r_cnt1 != '0);
  assign w_pop0     = rsp0_valid && rsp0_ready;
  assign w_pop1     = rsp1_valid && rsp1_ready;
  assign rsp0_y     = rsp0_valid ? r_fifo0[r_rd0] : 32'h0;
  assign rsp1_y     = rsp1_valid ? r_fifo1[r_rd1] : 32'h0;

  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_fifo0[r_wr0] <= sq_y;
    end
    if (w_push1) begin
      r_fifo1[r_wr1] <= sq_y;
    end
  end

  // Credits cover in-flight plus buffered results, so a push never finds a full FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr0   <= '0;
      r_rd0   <= '0;
      r_wr1   <= '0;
      r_rd1   <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
      r_cred0 <= '0;
      r_cred1 <= '0;
    end else begin
      if (w_push0) begin
        r_wr0 <= ptrNext(r_wr0);
      end
      if (w_pop0) begin
        r_rd0 <= ptrNext(r_rd0);
      end
      if (w_push1) begin
        r_wr1 <= ptrNext(r_wr1);
      end
      if (w_pop1) begin
        r_rd1 <= ptrNext(r_rd1);
      end
      r_cnt0  <= countNext(r_cnt0, w_push0, w_pop0);
      r_cnt1  <= countNext(r_cnt1, w_push1, w_pop1);
      r_cred0 <= countNext(r_cred0, w_grant0, w_pop0);
      r_cred1 <= countNext(r_cred1, w_grant1, w_pop1);
    end
  end

  assign busy = (r_cred0 != '0) || (r_cred1 != '0);

`ifdef FSQRT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt0 <= 32'h0;
      issue_cnt1 <= 32'h0;
    end else begin
      if (w_grant0) begin
        issue_cnt0 <= issue_cnt0 + 32'h1;
      end
      if (w_grant1) begin
        issue_cnt1 <= issue_cnt1 + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fsqrt_sched.sv
// Directed bench for fsqrt_sched; the shared pipeline is modelled as sq_y = ~sq_x delayed LAT cycles.
module tb_fsqrt_sched;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_x, req1_x;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_y, rsp1_y, sq_x, sq_y;
  logic        busy;
`ifdef FSQRT_SCHED_PERF_EN
  logic [31:0] issue_cnt0, issue_cnt1;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  fsqrt_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
    .sq_x(sq_x), .sq_y(sq_y), .busy(busy)
`ifdef FSQRT_SCHED_PERF_EN
    , .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mdlPipe [LAT];
  always_ff @(posedge clk) begin
    mdlPipe[0] <= ~sq_x;
    for (int i = 1; i < LAT; i++) mdlPipe[i] <= mdlPipe[i-1];
  end
  assign sq_y = mdlPipe[LAT-1];

  typedef struct {
    logic        rst;
    logic [3:0]  ctl;   // {v0, v1, rr0, rr1}
    logic [31:0] x0;
    logic [31:0] x1;
    logic [4:0]  exp;   // {rdy0, rdy1, rv0, rv1, busy}
    logic [31:0] eSqx;
    logic [31:0] eRy0;
    logic [31:0] eRy1;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic [3:0] ctl, input logic [31:0] x0,
                        input logic [31:0] x1, input logic [4:0] exp, input logic [31:0] eSqx,
                        input logic [31:0] eRy0, input logic [31:0] eRy1);
    vec_t v;
    v.rst = rst; v.ctl = ctl; v.x0 = x0; v.x1 = x1;
    v.exp = exp; v.eSqx = eSqx; v.eRy0 = eRy0; v.eRy1 = eRy1;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] x0, input logic v1,
                               input logic [31:0] x1, input logic rr0, input logic rr1);
    req0_valid = v0; req0_x = x0;
    req1_valid = v1; req1_x = x1;
    rsp0_ready = rr0; rsp1_ready = rr1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Holds rstn low across one rising edge with requests asserted; every output must read 0.
  task automatic doReset;
    applyStimulus(1'b1, 32'h12345678, 1'b1, 32'h9ABCDEF0, 1'b1, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("rst req0_ready", {31'h0, req0_ready}, 32'h0);
    checkOutput("rst req1_ready", {31'h0, req1_ready}, 32'h0);
    checkOutput("rst sq_x", sq_x, 32'h0);
    checkOutput("rst rsp0_valid", {31'h0, rsp0_valid}, 32'h0);
    checkOutput("rst rsp1_valid", {31'h0, rsp1_valid}, 32'h0);
    checkOutput("rst busy", {31'h0, busy}, 32'h0);
`ifdef FSQRT_SCHED_PERF_EN
    checkOutput("rst issue_cnt0", issue_cnt0, 32'h0);
    checkOutput("rst issue_cnt1", issue_cnt1, 32'h0);
`endif
    nextCycle();
    rstn = 1'b1;
  endtask

  initial begin
    int grants;
    int lat;
    logic [31:0] latY;
    rstn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;

    // Single issue, contention from reset, and per-port ordering.
    addVec(1'b1, 4'b1011, 32'h40800000, 32'h0, 5'b10000, 32'h40800000, 32'h0, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00101, 32'h0, 32'hBF7FFFFF, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0);

    addVec(1'b1, 4'b1111, 32'h1, 32'h2, 5'b10000, 32'h1, 32'h0, 32'h0);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b01001, 32'h2, 32'h0, 32'h0);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b10001, 32'h1, 32'h0, 32'h0);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b01001, 32'h2, 32'h0, 32'h0);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b10101, 32'h1, 32'hFFFFFFFE, 32'h0);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b01011, 32'h2, 32'h0, 32'hFFFFFFFD);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b10101, 32'h1, 32'hFFFFFFFE, 32'h0);
    addVec(1'b0, 4'b1111, 32'h1, 32'h2, 5'b01011, 32'h2, 32'h0, 32'hFFFFFFFD);

    addVec(1'b1, 4'b1011, 32'h3F800000, 32'h0, 5'b10000, 32'h3F800000, 32'h0, 32'h0);
    addVec(1'b0, 4'b1011, 32'h41800000, 32'h0, 5'b10001, 32'h41800000, 32'h0, 32'h0);
    addVec(1'b0, 4'b1011, 32'h0, 32'h0, 5'b10001, 32'h0, 32'h0, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00101, 32'h0, 32'hC07FFFFF, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00101, 32'h0, 32'hBE7FFFFF, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00101, 32'h0, 32'hFFFFFFFF, 32'h0);
    addVec(1'b0, 4'b0011, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].ctl[3], vecs[i].x0, vecs[i].ctl[2], vecs[i].x1,
                    vecs[i].ctl[1], vecs[i].ctl[0]);
      @(negedge clk);
      checkOutput($sformatf("row%0d req0_ready", i), {31'h0, req0_ready}, {31'h0, vecs[i].exp[4]});
      checkOutput($sformatf("row%0d req1_ready", i), {31'h0, req1_ready}, {31'h0, vecs[i].exp[3]});
      checkOutput($sformatf("row%0d rsp0_valid", i), {31'h0, rsp0_valid}, {31'h0, vecs[i].exp[2]});
      checkOutput($sformatf("row%0d rsp1_valid", i), {31'h0, rsp1_valid}, {31'h0, vecs[i].exp[1]});
      checkOutput($sformatf("row%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].exp[0]});
      checkOutput($sformatf("row%0d sq_x", i), sq_x, vecs[i].eSqx);
      checkOutput($sformatf("row%0d rsp0_y", i), rsp0_y, vecs[i].eRy0);
      checkOutput($sformatf("row%0d rsp1_y", i), rsp1_y, vecs[i].eRy1);
      nextCycle();
    end

    // Backpressure: port 0 saturates its credits, port 1 still gets through.
    doReset();
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      if (req0_ready) grants++;
      nextCycle();
    end
    checkOutput("bp grant count", 32'(grants), 32'd4);
    applyStimulus(1'b1, 32'h3F800000, 1'b1, 32'h2, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp port1 ready0", {31'h0, req0_ready}, 32'h0);
    checkOutput("bp port1 ready1", {31'h0, req1_ready}, 32'h1);
    nextCycle();
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp pop rsp0_valid", {31'h0, rsp0_valid}, 32'h1);
    checkOutput("bp pop rsp0_y", rsp0_y, 32'hC07FFFFF);
    checkOutput("bp pop ready0", {31'h0, req0_ready}, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp freed ready0", {31'h0, req0_ready}, 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("bp refull ready0", {31'h0, req0_ready}, 32'h0);
    nextCycle();

    // Reset mid-operation: in-flight results must be dropped.
    doReset();
    applyStimulus(1'b1, 32'h40800000, 1'b0, 32'h0, 1'b1, 1'b1);
    nextCycle();
    nextCycle();
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midop c%0d rsp0_valid", k), {31'h0, rsp0_valid}, 32'h0);
      checkOutput($sformatf("midop c%0d busy", k), {31'h0, busy}, 32'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h40800000, 1'b0, 32'h0, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    lat = -1;
    latY = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rsp0_valid) begin
        lat = k;
        latY = rsp0_y;
        break;
      end
      nextCycle();
    end
    checkOutput("midop next latency", 32'(lat), 32'd4);
    checkOutput("midop next rsp0_y", latY, 32'hBF7FFFFF);
    nextCycle();

`ifdef FSQRT_SCHED_PERF_EN
    begin
      int n0, n1;
      doReset();
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 100 && (n0 < 10 || n1 < 7); k++) begin
        applyStimulus(n0 < 10, 32'h1, n1 < 7, 32'h2, 1'b1, 1'b1);
        @(negedge clk);
        if (req0_valid && req0_ready) n0++;
        if (req1_valid && req1_ready) n1++;
        nextCycle();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("perf issue_cnt0", issue_cnt0, 32'd10);
      checkOutput("perf issue_cnt1", issue_cnt1, 32'd7);
      nextCycle();
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("perf cleared cnt0", issue_cnt0, 32'h0);
      checkOutput("perf cleared cnt1", issue_cnt1, 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
